// File: rtl/sid_wr_arb.sv
// SID write arbiter: merges CPU SID accesses with a queued host write
// stream. The CPU always wins the bus. At most one host write is issued
// per 1 MHz SID period, in a CPU-free clk.
module sid_wr_arb #(
  parameter int unsigned DUAL       = 1,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ce_1m,
  input  logic [1:0] cpu_cs,
  input  logic       cpu_we,
  input  logic [4:0] cpu_addr,
  input  logic [7:0] cpu_din,
  output logic [7:0] cpu_dout,
  input  logic       h_valid,
  output logic       h_ready,
  input  logic       h_sel,
  input  logic [4:0] h_addr,
  input  logic [7:0] h_data,
  input  logic       h_flush,
  output logic [4:0] h_level,
  output logic [7:0] drop_cnt,
  output logic [1:0] sid_cs,
  output logic       sid_we,
  output logic [4:0] sid_addr,
  output logic [7:0] sid_wdata,
  input  logic [7:0] sid_rdata
);

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 8;
  localparam int unsigned LW = 5;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic          sel;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARM   = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  entry_t        r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_ready;
  logic [7:0]    r_drop;
  state_t        r_state;

  logic [1:0]    r_sid_cs;
  logic          r_sid_we;
  logic [AW-1:0] r_sid_addr;
  logic [DW-1:0] r_sid_wdata;

  state_t        w_state_nxt;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_full;
  logic [1:0]    w_cpu_cs;
  logic          w_cpu_act;
  logic [LW-1:0] w_level_nxt;
  entry_t        w_wr_entry;
  entry_t        w_head;

  // CPU chip-select with chip 1 masked off in single-SID builds
  always_comb begin
    w_cpu_cs = cpu_cs;
    if (DUAL == 0) w_cpu_cs = {1'b0, cpu_cs[0]};
    w_cpu_act = |w_cpu_cs;
  end

  // FIFO handshake: a push coincident with flush is silently discarded
  always_comb begin
    w_full     = (r_level == LW'(FIFO_DEPTH));
    w_push     = h_valid & r_ready & ~h_flush;
    w_drop     = h_valid & w_full & ~h_flush;
    w_wr_entry.sel  = (DUAL != 0) ? h_sel : 1'b0;
    w_wr_entry.addr = h_addr;
    w_wr_entry.data = h_data;
    w_head     = r_mem[r_rd_ptr];
  end

  // Next occupancy from push/pop, cleared by flush
  always_comb begin
    w_level_nxt = r_level;
    if (h_flush)              w_level_nxt = '0;
    else if (w_push && !w_pop) w_level_nxt = r_level + LW'(1);
    else if (!w_push && w_pop) w_level_nxt = r_level - LW'(1);
  end

  // Arbiter next-state: arm on ce_1m, issue on the first CPU-free clk
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!h_flush && ce_1m && (r_level != '0)) w_state_nxt = S_ARM;
      end
      S_ARM: begin
        if (h_flush) begin
          w_state_nxt = S_IDLE;
        end else if (!w_cpu_act) begin
          w_state_nxt = S_ISSUE;
          w_pop       = 1'b1;
        end
      end
      S_ISSUE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FIFO storage; contents need no reset, pointers gate validity
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_wr_entry;
  end

  // FIFO pointers, occupancy, ready flag and saturating drop counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_ready  <= 1'b0;
      r_drop   <= '0;
    end else begin
      r_level <= w_level_nxt;
      r_ready <= (w_level_nxt != LW'(FIFO_DEPTH));
      if (h_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
    end
  end

  // Registered SID bus: CPU first, else the popped host entry, else idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sid_cs    <= '0;
      r_sid_we    <= 1'b0;
      r_sid_addr  <= '0;
      r_sid_wdata <= '0;
    end else if (w_cpu_act) begin
      r_sid_cs    <= w_cpu_cs;
      r_sid_we    <= cpu_we;
      r_sid_addr  <= cpu_addr;
      r_sid_wdata <= cpu_din;
    end else if (w_pop) begin
      r_sid_cs    <= w_head.sel ? 2'b10 : 2'b01;
      r_sid_we    <= 1'b1;
      r_sid_addr  <= w_head.addr;
      r_sid_wdata <= w_head.data;
    end else begin
      r_sid_cs    <= '0;
      r_sid_we    <= 1'b0;
      r_sid_addr  <= '0;
      r_sid_wdata <= '0;
    end
  end

  assign h_ready   = r_ready;
  assign h_level   = r_level;
  assign drop_cnt  = r_drop;
  assign sid_cs    = r_sid_cs;
  assign sid_we    = r_sid_we;
  assign sid_addr  = r_sid_addr;
  assign sid_wdata = r_sid_wdata;
  assign cpu_dout  = sid_rdata;

endmodule
